muldiv_seq_unit: RTL and testbench

- Iterative multiply/divide unit with its own SPECIAL-funct decode front end; owns the HI/LO register pair.
- Sits beside the ALU in the execute stage.
- Accepts mult/multu/div/divu/mfhi/mflo/mthi/mtlo and drives a stall to the pipeline while an operation is in flight.
- Successor to the combinational funct decoder: adds a parametrised datapath width and radix, an FSM, multi-cycle latency and hazard stalls.

---
 rtl/muldiv_seq_unit.sv | 180 ++++++++++++++++++
 tb/tb_muldiv_seq_unit.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq_unit.sv
// Iterative multiply/divide unit with SPECIAL-funct decode; owns HI/LO.
// Retires BITS_PER_CYCLE bits per cycle, then a one-cycle sign fix-up writes HI/LO.
module muldiv_seq_unit #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic [5:0]       op_i,
  input  logic [5:0]       ft_i,
  input  logic [WIDTH-1:0] rs_val_i,
  input  logic [WIDTH-1:0] rt_val_i,
  output logic             is_md_o,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             rd_we_o,
  output logic [WIDTH-1:0] rd_data_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int WB = WIDTH + BITS_PER_CYCLE;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] F_MFHI     = 6'b010000;
  localparam logic [5:0] F_MTHI     = 6'b010001;
  localparam logic [5:0] F_MFLO     = 6'b010010;
  localparam logic [5:0] F_MTLO     = 6'b010011;
  localparam logic [5:0] F_MULT     = 6'b011000;
  localparam logic [5:0] F_MULTU    = 6'b011001;
  localparam logic [5:0] F_DIV      = 6'b011010;
  localparam logic [5:0] F_DIVU     = 6'b011011;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;

  logic            mul_q;
  logic            neg_a;
  logic            neg_b;
  logic            zero_div;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] hi_acc;
  logic [WIDTH-1:0] lo_acc;

  logic            go;
  logic            start;
  logic            sgn_op;
  logic            mul_op;

  logic [WB-1:0]    mul_sum;
  logic [WIDTH-1:0] div_r;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  // Decode and hazard front end
  assign is_md_o = valid_i && (op_i == OP_SPECIAL) &&
                   (ft_i inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO,
                                 F_MULT, F_MULTU, F_DIV, F_DIVU});
  assign busy_o  = (state != IDLE);
  assign stall_o = is_md_o && busy_o;
  assign go      = is_md_o && !stall_o;
  assign start   = go && (ft_i inside {F_MULT, F_MULTU, F_DIV, F_DIVU});
  assign rd_we_o = go && (ft_i == F_MFHI || ft_i == F_MFLO);
  assign sgn_op  = ~ft_i[0];
  assign mul_op  = ~ft_i[1];

  always_comb begin
    rd_data_o = '0;
    if (is_md_o && ft_i == F_MFHI)      rd_data_o = hi_o;
    else if (is_md_o && ft_i == F_MFLO) rd_data_o = lo_o;
  end

  // One iteration of shift-add multiply or restoring divide
  // NOTE: blocking assignments here build a chain of combinational steps inside one cycle.
  always_comb begin
    mul_sum = {{BITS_PER_CYCLE{1'b0}}, hi_acc} +
              WB'(opa) * WB'(lo_acc[BITS_PER_CYCLE-1:0]);
    div_r  = hi_acc;
    div_q  = lo_acc;
    div_sh = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      div_sh = {div_r, div_q[WIDTH-1]};
      div_q  = {div_q[WIDTH-2:0], 1'b0};
      if (div_sh >= {1'b0, opa}) begin
        div_sh   = div_sh - {1'b0, opa};
        div_q[0] = 1'b1;
      end
      div_r = div_sh[WIDTH-1:0];
    end
    if (mul_q) begin
      step_hi = mul_sum[WB-1:BITS_PER_CYCLE];
      step_lo = {mul_sum[BITS_PER_CYCLE-1:0], lo_acc[WIDTH-1:BITS_PER_CYCLE]};
    end else begin
      step_hi = div_r;
      step_lo = div_q;
    end
  end

  // Sign fix-up; a zero divisor leaves the remainder as rs and forces quotient to all ones
  always_comb begin
    prod = {hi_acc, lo_acc};
    if (neg_a ^ neg_b) prod = -prod;
    quo = lo_acc;
    if (neg_a ^ neg_b) quo = -quo;
    if (zero_div) quo = '1;
    rem = neg_a ? -hi_acc : hi_acc;
    fix_hi = mul_q ? prod[2*WIDTH-1:WIDTH] : rem;
    fix_lo = mul_q ? prod[WIDTH-1:0]       : quo;
  end

  // NOTE: the iteration datapath carries no reset; it is always loaded at issue before use.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      mul_q    <= mul_op;
      neg_a    <= sgn_op && rs_val_i[WIDTH-1];
      neg_b    <= sgn_op && rt_val_i[WIDTH-1];
      zero_div <= (rt_val_i == '0);
      opa      <= mul_op ? mag(rs_val_i, sgn_op) : mag(rt_val_i, sgn_op);
      lo_acc   <= mul_op ? mag(rt_val_i, sgn_op) : mag(rs_val_i, sgn_op);
      hi_acc   <= '0;
    end else if (state == RUN) begin
      hi_acc <= step_hi;
      lo_acc <= step_lo;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      hi_o   <= '0;
      lo_o   <= '0;
      done_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt   <= '0;
            state <= RUN;
          end else if (go && ft_i == F_MTHI) begin
            hi_o <= rs_val_i;
          end else if (go && ft_i == F_MTLO) begin
            lo_o <= rs_val_i;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) state <= FIX;
        end
        FIX: begin
          hi_o   <= fix_hi;
          lo_o   <= fix_lo;
          done_o <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq_unit.sv
// Self-checking bench for muldiv_seq_unit: radix-2 and radix-16 instances
// against an arithmetic reference model.
module tb_muldiv_seq_unit;

  localparam int W = 32;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   valid = '0;
  logic [5:0]   op = '0;
  logic [5:0]   ft = '0;
  logic [W-1:0] rs = '0;
  logic [W-1:0] rt = '0;

  logic [1:0]   is_md, stall, busy, done, rd_we;
  logic [W-1:0] rd_data [2];
  logic [W-1:0] hi_s [2];
  logic [W-1:0] lo_s [2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  muldiv_seq_unit #(.WIDTH(W), .BITS_PER_CYCLE(1)) dut_r1 (
    .clk(clk), .rst_n(rst_n), .valid_i(valid[0]), .op_i(op), .ft_i(ft),
    .rs_val_i(rs), .rt_val_i(rt), .is_md_o(is_md[0]), .stall_o(stall[0]),
    .busy_o(busy[0]), .done_o(done[0]), .rd_we_o(rd_we[0]),
    .rd_data_o(rd_data[0]), .hi_o(hi_s[0]), .lo_o(lo_s[0])
  );

  muldiv_seq_unit #(.WIDTH(W), .BITS_PER_CYCLE(4)) dut_r4 (
    .clk(clk), .rst_n(rst_n), .valid_i(valid[1]), .op_i(op), .ft_i(ft),
    .rs_val_i(rs), .rt_val_i(rt), .is_md_o(is_md[1]), .stall_o(stall[1]),
    .busy_o(busy[1]), .done_o(done[1]), .rd_we_o(rd_we[1]),
    .rd_data_o(rd_data[1]), .hi_o(hi_s[1]), .lo_o(lo_s[1])
  );

  // Reference: plain 64-bit arithmetic, C-style truncating division
  function automatic void ref_md(input logic [5:0] f, input logic [W-1:0] a, b,
                                 output logic [W-1:0] h, output logic [W-1:0] l);
    longint sa, sb, sq, sr;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    h = '0;
    l = '0;
    case (f)
      F_MULT: begin
        p = sa * sb;
        h = p[63:32];
        l = p[31:0];
      end
      F_MULTU: begin
        p = {32'b0, a} * {32'b0, b};
        h = p[63:32];
        l = p[31:0];
      end
      F_DIV: begin
        if (b == '0) begin
          h = a;
          l = '1;
        end else begin
          sq = sa / sb;
          sr = sa % sb;
          l = sq[31:0];
          h = sr[31:0];
        end
      end
      F_DIVU: begin
        if (b == '0) begin
          h = a;
          l = '1;
        end else begin
          l = a / b;
          h = a % b;
        end
      end
      default: ;
    endcase
  endfunction

  function automatic logic [5:0] rand_arith();
    case ($urandom_range(0, 3))
      0:       return F_MULT;
      1:       return F_MULTU;
      2:       return F_DIV;
      default: return F_DIVU;
    endcase
  endfunction

  // Issue one mult/div and watch the full busy window on the selected instance
  task automatic run_op(input int s, input logic [5:0] f, input logic [W-1:0] a, b,
                        input string tag);
    logic [W-1:0] eh, el;
    int bc, dc, n;
    n = (s == 0) ? 33 : 9;
    ref_md(f, a, b, eh, el);
    @(negedge clk);
    op = 6'b000000; ft = f; rs = a; rt = b; valid[s] = 1'b1;
    @(posedge clk);
    #1 valid[s] = 1'b0;
    bc = 0;
    dc = 0;
    repeat (45) begin
      @(negedge clk);
      if (busy[s]) bc++;
      if (done[s]) dc++;
    end
    checks += 4;
    if (bc !== n) begin
      failures++;
      $display("FAIL %s busy_cycles actual=%0d required=%0d", tag, bc, n);
    end
    if (dc !== 1) begin
      failures++;
      $display("FAIL %s done_pulses actual=%0d required=1", tag, dc);
    end
    if (hi_s[s] !== eh) begin
      failures++;
      $display("FAIL %s hi rs=%h rt=%h actual=%h required=%h", tag, a, b, hi_s[s], eh);
    end
    if (lo_s[s] !== el) begin
      failures++;
      $display("FAIL %s lo rs=%h rt=%h actual=%h required=%h", tag, a, b, lo_s[s], el);
    end
  endtask

  task automatic read_reg(input int s, input logic [5:0] f, input logic [W-1:0] exp,
                          input string tag);
    @(negedge clk);
    op = 6'b000000; ft = f; valid[s] = 1'b1;
    #1;
    checks += 3;
    if (stall[s] !== 1'b0) begin
      failures++;
      $display("FAIL %s stall actual=%b required=0", tag, stall[s]);
    end
    if (rd_we[s] !== 1'b1) begin
      failures++;
      $display("FAIL %s rd_we actual=%b required=1", tag, rd_we[s]);
    end
    if (rd_data[s] !== exp) begin
      failures++;
      $display("FAIL %s rd_data actual=%h required=%h", tag, rd_data[s], exp);
    end
    @(posedge clk);
    #1 valid[s] = 1'b0;
  endtask

  task automatic write_reg(input int s, input logic [5:0] o, input logic [5:0] f,
                           input logic [W-1:0] v);
    @(negedge clk);
    op = o; ft = f; rs = v; valid[s] = 1'b1;
    @(posedge clk);
    #1 valid[s] = 1'b0;
    op = 6'b000000;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      checks += 4;
      if (busy[s] !== 1'b0) begin failures++; $display("FAIL reset_busy[%0d] actual=%b required=0", s, busy[s]); end
      if (done[s] !== 1'b0) begin failures++; $display("FAIL reset_done[%0d] actual=%b required=0", s, done[s]); end
      if (hi_s[s] !== '0) begin failures++; $display("FAIL reset_hi[%0d] actual=%h required=0", s, hi_s[s]); end
      if (lo_s[s] !== '0) begin failures++; $display("FAIL reset_lo[%0d] actual=%h required=0", s, lo_s[s]); end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    run_op(0, F_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, "multu_ffff_x2");
    checks += 2;
    if (hi_s[0] !== 32'h0000_0001) begin failures++; $display("FAIL multu_hi_const actual=%h required=00000001", hi_s[0]); end
    if (lo_s[0] !== 32'hFFFF_FFFE) begin failures++; $display("FAIL multu_lo_const actual=%h required=fffffffe", lo_s[0]); end
    run_op(0, F_MULT, 32'hFFFF_FFFD, 32'd7, "mult_m3_x7");
    read_reg(0, F_MFHI, 32'hFFFF_FFFF, "mfhi_after_mult");
    read_reg(0, F_MFLO, 32'hFFFF_FFEB, "mflo_after_mult");
    run_op(0, F_DIV, 32'hFFFF_FFF9, 32'd2, "div_m7_by2");
    checks += 2;
    if (lo_s[0] !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_lo_const actual=%h required=fffffffd", lo_s[0]); end
    if (hi_s[0] !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_hi_const actual=%h required=ffffffff", hi_s[0]); end
    run_op(0, F_DIVU, 32'd7, 32'd0, "divu_by_zero");
    run_op(0, F_DIV, 32'hFFFF_FFF9, 32'd0, "div_signed_by_zero");
    run_op(0, F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
  endtask

  task automatic test_moves();
    logic [W-1:0] v1, v2, v3;
    v1 = $urandom();
    v2 = $urandom();
    v3 = ~v1;
    write_reg(0, 6'b000000, F_MTHI, v1);
    write_reg(0, 6'b000000, F_MTLO, v2);
    read_reg(0, F_MFHI, v1, "mfhi_after_mthi");
    read_reg(0, F_MFLO, v2, "mflo_after_mtlo");
    write_reg(0, 6'b000001, F_MTHI, v3);
    @(negedge clk);
    op = 6'b000000; ft = 6'b100000; valid[0] = 1'b1;
    #1;
    checks += 3;
    if (hi_s[0] !== v1) begin failures++; $display("FAIL non_special_mthi hi actual=%h required=%h", hi_s[0], v1); end
    if (is_md[0] !== 1'b0) begin failures++; $display("FAIL add_funct is_md actual=%b required=0", is_md[0]); end
    if (rd_we[0] !== 1'b0) begin failures++; $display("FAIL add_funct rd_we actual=%b required=0", rd_we[0]); end
    @(posedge clk);
    #1 valid[0] = 1'b0;
  endtask

  task automatic test_stall();
    logic [W-1:0] a, b, eh, el, lo_before;
    a = $urandom();
    b = $urandom_range(1, 5000);
    ref_md(F_DIVU, a, b, eh, el);
    lo_before = lo_s[0];
    @(negedge clk);
    op = 6'b000000; ft = F_DIVU; rs = a; rt = b; valid[0] = 1'b1;
    @(posedge clk);
    #1 valid[0] = 1'b0;
    ft = F_MFLO;
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      valid[0] = 1'b1;
      #1;
      checks += 2;
      if (stall[0] !== 1'b1) begin failures++; $display("FAIL stall_cycle%0d stall actual=%b required=1", c, stall[0]); end
      if (lo_s[0] !== lo_before) begin failures++; $display("FAIL stall_cycle%0d lo actual=%h required=%h", c, lo_s[0], lo_before); end
    end
    @(negedge clk);
    valid[0] = 1'b0;
    #1;
    checks++;
    if (done[0] !== 1'b1) begin failures++; $display("FAIL stall_done actual=%b required=1", done[0]); end
    read_reg(0, F_MFLO, el, "mflo_after_done");
  endtask

  task automatic test_reset_midrun();
    write_reg(0, 6'b000000, F_MTHI, $urandom() | 32'h1);
    write_reg(0, 6'b000000, F_MTLO, $urandom() | 32'h1);
    @(negedge clk);
    op = 6'b000000; ft = F_MULT; rs = $urandom(); rt = $urandom(); valid[0] = 1'b1;
    @(posedge clk);
    #1 valid[0] = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (busy[0] !== 1'b0) begin failures++; $display("FAIL midrun_reset busy actual=%b required=0", busy[0]); end
    if (done[0] !== 1'b0) begin failures++; $display("FAIL midrun_reset done actual=%b required=0", done[0]); end
    if (hi_s[0] !== '0) begin failures++; $display("FAIL midrun_reset hi actual=%h required=0", hi_s[0]); end
    if (lo_s[0] !== '0) begin failures++; $display("FAIL midrun_reset lo actual=%h required=0", lo_s[0]); end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, F_MULT, $urandom(), $urandom(), "mult_after_reset");
  endtask

  task automatic test_radix4();
    run_op(1, F_MULT, 32'h1234_5678, 32'h9ABC_DEF0, "r4_mult_ref");
    run_op(1, F_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, "r4_multu_ref");
    run_op(1, F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "r4_div_overflow");
    run_op(1, F_DIVU, $urandom(), 32'd0, "r4_divu_zero");
  endtask

  task automatic test_random();
    logic [5:0] f;
    logic [W-1:0] a, b;
    for (int i = 0; i < 24; i++) begin
      f = rand_arith();
      a = $urandom();
      b = $urandom();
      if (i % 6 == 1) b = b & 32'h0000_00FF;
      if (i % 8 == 5) b = '0;
      run_op(i % 2, f, a, b, (i % 2 == 0) ? "rand_r1" : "rand_r4");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_moves();
    test_stall();
    test_reset_midrun();
    test_radix4();
    test_random();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
